// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp: data-memory slave for the LSU request/response protocol.
// Word-organised array with byte/halfword/word stores and load results that
// leave already zero- or sign-extended. Responses come out of a LATENCY-deep
// pipeline, one per granted request, in order.
// Optional feature: define RISCV_DMEM_STALL_EN to insert pseudo-random wait
// states on the grant, driven by a 16-bit LFSR.
// data_dtype encoding: bit 2 = sign-extend, bits [1:0] = size (0 byte,
// 1 halfword, 2/3 word).
module riscv_dmem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  output logic        data_gnt,
  input  logic        data_op,
  input  logic [2:0]  data_dtype,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic       LSU_OP_LD = 1'b0;
  localparam logic       LSU_OP_WR = 1'b1;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  off);
    logic [31:0]        lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    lane   = word >> {off, 3'b000};
    byte_s = lane[7:0];
    half_s = lane[15:0];
    if (size == SZ_BYTE) begin
      res = sgn ? 32'(byte_s) : {24'b0, lane[7:0]};
    end else if (size == SZ_HALF) begin
      res = sgn ? 32'(half_s) : {16'b0, lane[15:0]};
    end else begin
      res = word;
    end
    return res;
  endfunction

  logic [31:0]      mem_q [DEPTH];

  logic             gnt_ok;
  logic             xfer;
  logic [1:0]       size;
  logic [1:0]       off;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             misalign;
  logic             out_of_range;
  logic             acc_err;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      rd_word;
  logic [31:0]      rsp_rdata_d;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [31:0]        rdata_q [LATENCY];

`ifdef RISCV_DMEM_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, shifted right one step per cycle.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign gnt_ok = lfsr_q[0];
`else
  assign gnt_ok = 1'b1;
`endif

  // Grant is combinational; nothing is accepted while reset is held.
  assign data_gnt = data_req && gnt_ok && !rst;
  assign xfer     = data_gnt;

  // Request decode: alignment, range, byte enables, lane replication, load data.
  always_comb begin
    size         = data_dtype[1:0];
    off          = data_addr[1:0];
    word_idx     = {2'b00, data_addr[31:2]};
    mem_idx      = data_addr[IDX_W+1:2];
    misalign     = ((size == SZ_HALF) && off[0]) ||
                   ((size[1] == 1'b1) && (off != 2'b00));
    out_of_range = (word_idx >= DEPTH);
    acc_err      = misalign || out_of_range;
    be           = 4'b1111;
    wlanes       = data_wdata;
    if (size == SZ_BYTE) begin
      be     = 4'b0001 << off;
      wlanes = {4{data_wdata[7:0]}};
    end else if (size == SZ_HALF) begin
      be     = 4'b0011 << off;
      wlanes = {2{data_wdata[15:0]}};
    end
    rd_word     = out_of_range ? 32'h0 : mem_q[mem_idx];
    rsp_rdata_d = 32'h0;
    if ((data_op == LSU_OP_LD) && !acc_err) begin
      rsp_rdata_d = load_extend(rd_word, size, data_dtype[2], off);
    end
  end

  // Byte-enabled store into the array in the transfer cycle; errors never write.
  always_ff @(posedge clk) begin
    if (xfer && (data_op == LSU_OP_WR) && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[mem_idx][b*8 +: 8] <= wlanes[b*8 +: 8];
      end
    end
  end

  // Response valid shift register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= xfer;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Response payload shift register; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    err_q[0]   <= acc_err;
    rdata_q[0] <= rsp_rdata_d;
    for (int i = 1; i < LATENCY; i++) begin
      err_q[i]   <= err_q[i-1];
      rdata_q[i] <= rdata_q[i-1];
    end
  end

  assign data_rvalid = vld_q[LATENCY-1] && !rst;
  assign data_rdata  = data_rvalid ? rdata_q[LATENCY-1] : 32'h0;
  assign data_err    = data_rvalid && err_q[LATENCY-1];

endmodule
